// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment bus (active-low an/seg),
// used by both the capture side and the display driver.
package seven_seg_pkg;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode codes, active-low, one line per digit position
  localparam logic [3:0] AN_D0 = 4'b0111;
  localparam logic [3:0] AN_D1 = 4'b1011;
  localparam logic [3:0] AN_D2 = 4'b1101;
  localparam logic [3:0] AN_D3 = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } an_slot_t;

  // Anything other than exactly one low anode line is not a digit slot.
  function automatic an_slot_t an_to_slot(input logic [3:0] an);
    an_slot_t s;
    s.valid = 1'b0;
    s.idx   = 2'd0;
    case (an)
      AN_D0: begin s.valid = 1'b1; s.idx = 2'd0; end
      AN_D1: begin s.valid = 1'b1; s.idx = 2'd1; end
      AN_D2: begin s.valid = 1'b1; s.idx = 2'd2; end
      AN_D3: begin s.valid = 1'b1; s.idx = 2'd3; end
      default: begin s.valid = 1'b0; s.idx = 2'd0; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bus between a seven-segment display source (master) and the capture block (slave).
// frame_valid is a one-cycle strobe with no back-pressure: d0..d3 and seg_err are valid on it and held until the next strobe.
interface seven_seg_capture_if;
  import seven_seg_pkg::*;

  logic [3:0]   an_in;
  logic [6:0]   seg_in;
  logic [3:0]   d0;
  logic [3:0]   d1;
  logic [3:0]   d2;
  logic [3:0]   d3;
  logic         frame_valid;
  logic         seg_err;
  logic         stale;
  frame_state_e dbg_state;

  modport master (
    output an_in, seg_in,
    input  d0, d1, d2, d3, frame_valid, seg_err, stale, dbg_state
  );

  modport slave (
    input  an_in, seg_in,
    output d0, d1, d2, d3, frame_valid, seg_err, stale, dbg_state
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern to nibble decoder. Define SEVEN_SEG_HEX_EN to accept A-F;
// otherwise those patterns are flagged illegal like any other unknown pattern.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'hF;
    illegal = 1'b0;
    case (seg)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
`ifdef SEVEN_SEG_HEX_EN
      SEG_A:     digit = 4'hA;
      SEG_B:     digit = 4'hB;
      SEG_C:     digit = 4'hC;
      SEG_D:     digit = 4'hD;
      SEG_E:     digit = 4'hE;
      SEG_F:     digit = 4'hF;
`endif
      SEG_BLANK: digit = 4'hF;
      default: begin
        digit   = 4'hF;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of a scanned 4-digit seven-segment bus: sync, debounce, decode, frame assembly, timeout.
// SEVEN_SEG_HEX_EN (see seven_seg_decode) enables A-F decoding.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_capture_if.slave bus
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  logic [10:0]       sync1_q, sync1_d;
  logic [10:0]       sync2_q, sync2_d;
  logic [10:0]       prev_q, prev_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  frame_state_e      state_q, state_d;
  logic [3:0]        seen_q, seen_d;
  logic              frame_err_q, frame_err_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [3:0][3:0]   dout_q, dout_d;
  logic              frame_valid_q, frame_valid_d;
  logic              seg_err_q, seg_err_d;

  logic            same;
  logic            accept;
  logic            acc_ok;
  logic            stale_w;
  an_slot_t        slot;
  logic [3:0]      dec_digit;
  logic            dec_illegal;
  logic [3:0][3:0] shadow_n;
  logic [3:0]      seen_n;
  logic            err_n;

  seven_seg_decode u_decode (
    .seg     (sync2_q[6:0]),
    .digit   (dec_digit),
    .illegal (dec_illegal)
  );

  // Input path and stability window. The counter parks at STABLE_CYCLES after an
  // accept so a long-held digit is taken only once per stable window.
  always_comb begin
    sync1_d = {bus.an_in, bus.seg_in};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    same    = (sync2_q == prev_q);
    if (!same) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
    accept  = same && (stab_cnt_q == STAB_ACC);
    slot    = an_to_slot(sync2_q[10:7]);
    acc_ok  = accept && slot.valid;
    stale_w = (to_cnt_q == TO_MAX);
    if (acc_ok) begin
      to_cnt_d = '0;
    end else if (!stale_w) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Frame assembly: shadows, mask and error as they would be after this accept.
  always_comb begin
    shadow_n           = shadow_q;
    shadow_n[slot.idx] = dec_digit;
    seen_n             = seen_q | (4'b0001 << slot.idx);
    err_n              = frame_err_q | dec_illegal;
  end

  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    frame_err_d   = frame_err_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    seg_err_d     = seg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_ok) begin
          shadow_d    = shadow_n;
          seen_d      = seen_n;
          frame_err_d = err_n;
          state_d     = ST_COLLECT;
        end else if (stale_w) begin
          seen_d = '0;
        end
      end
      ST_COLLECT: begin
        if (acc_ok) begin
          shadow_d    = shadow_n;
          seen_d      = seen_n;
          frame_err_d = err_n;
          // Outputs load on entry so they change on the same cycle frame_valid is high.
          if (seen_n == 4'b1111) begin
            state_d       = ST_PUBLISH;
            dout_d        = shadow_n;
            frame_valid_d = 1'b1;
            seg_err_d     = err_n;
          end
        end else if (stale_w) begin
          state_d = ST_IDLE;
          seen_d  = '0;
        end
      end
      ST_PUBLISH: begin
        seen_d      = '0;
        frame_err_d = 1'b0;
        state_d     = ST_COLLECT;
      end
      default: begin
        state_d = ST_IDLE;
        seen_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      stab_cnt_q    <= '0;
      to_cnt_q      <= '0;
      state_q       <= ST_IDLE;
      seen_q        <= '0;
      frame_err_q   <= 1'b0;
      shadow_q      <= '0;
      dout_q        <= {4{4'hF}};
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stab_cnt_q    <= stab_cnt_d;
      to_cnt_q      <= to_cnt_d;
      state_q       <= state_d;
      seen_q        <= seen_d;
      frame_err_q   <= frame_err_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
    end
  end

  assign bus.d0          = dout_q[0];
  assign bus.d1          = dout_q[1];
  assign bus.d2          = dout_q[2];
  assign bus.d3          = dout_q[3];
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.stale       = stale_w;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: run-length model of the scanned bus checked every cycle,
// plus literal expectations per scenario.
module tb_seven_seg_capture;
  import seven_seg_pkg::*;

  localparam int STABLE = 16;
  localparam int TMO    = 600;
  localparam int HOLD   = 40;
`ifdef SEVEN_SEG_HEX_EN
  localparam int NDEC = 16;
`else
  localparam int NDEC = 10;
`endif

  logic clk;
  logic rst_n;

  seven_seg_capture_if bus ();

  seven_seg_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference patterns 0-9, A-F
  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_assert = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;

  // Behavioural model state
  logic [10:0] last;
  int          run;
  logic        p0v, p1v;
  logic [10:0] p0, p1;
  logic [3:0]  m_sh [4];
  logic [3:0]  m_d [4];
  logic [3:0]  m_mask;
  logic        m_ferr, m_fv, m_err;
  int          m_to;

  function automatic void mdec(input logic [6:0] s, output logic [3:0] dg, output logic ill);
    dg  = 4'hF;
    ill = (s != 7'b1111111);
    for (int i = 0; i < NDEC; i++) begin
      if (s == pat[i]) begin
        dg  = 4'(i);
        ill = 1'b0;
      end
    end
  endfunction

  // A value held over STABLE+1 sampling edges is taken; its effect lands two edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last = '0; run = 0; p0v = 0; p1v = 0; p0 = '0; p1 = '0;
      m_mask = '0; m_ferr = 0; m_fv = 0; m_err = 0; m_to = 0;
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 4'h0;
        m_d[i]  = 4'hF;
      end
    end else begin
      logic [3:0]  dg;
      logic        ill;
      int          slot;
      logic [10:0] cur;
      m_fv = 0;
      slot = -1;
      if ($countones(~p1[10:7]) == 1) begin
        for (int i = 0; i < 4; i++) if (!p1[7+i]) slot = 3 - i;
      end
      if (p1v && slot >= 0) begin
        mdec(p1[6:0], dg, ill);
        m_sh[slot]   = dg;
        m_mask[slot] = 1'b1;
        m_ferr       = m_ferr | ill;
        m_to         = 0;
        if (m_mask == 4'hF) begin
          m_d    = m_sh;
          m_fv   = 1;
          m_err  = m_ferr;
          m_mask = '0;
          m_ferr = 0;
        end
      end else begin
        if (m_to == TMO) m_mask = '0;
        if (m_to < TMO) m_to++;
      end
      p1v = p0v;
      p1  = p0;
      cur = {bus.an_in, bus.seg_in};
      if (cur == last) begin
        if (run < 100000) run++;
      end else begin
        run  = 1;
        last = cur;
      end
      p0v = (run == STABLE + 1);
      p0  = cur;
    end
  end

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks (inputs change on the falling edge)
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    bus.an_in  = an;
    bus.seg_in = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan(input int slot, input logic [6:0] seg);
    logic [3:0] onehot;
    onehot = 4'b1000 >> slot;
    drive(~onehot, seg, HOLD);
  endtask

  task automatic rotate(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    scan(3, s3);
    scan(2, s2);
    scan(1, s1);
    scan(0, s0);
  endtask

  task automatic idle(input int cycles);
    drive(4'b1111, 7'b1111111, cycles);
  endtask

  task automatic chk_digits(input string tag, input logic [3:0] e3, input logic [3:0] e2,
                            input logic [3:0] e1, input logic [3:0] e0);
    chk({tag, "_d3"}, 32'(bus.d3), 32'(e3));
    chk({tag, "_d2"}, 32'(bus.d2), 32'(e2));
    chk({tag, "_d1"}, 32'(bus.d1), 32'(e1));
    chk({tag, "_d0"}, 32'(bus.d0), 32'(e0));
  endtask

  initial begin
    int f0;
    rst_n      = 1'b0;
    bus.an_in  = 4'b1111;
    bus.seg_in = 7'b1111111;

    fork
      forever begin
        @(negedge clk);
        if (bus.frame_valid === 1'b1) fv_cnt++;
        chk("cyc_d0", 32'(bus.d0), 32'(m_d[0]));
        chk("cyc_d1", 32'(bus.d1), 32'(m_d[1]));
        chk("cyc_d2", 32'(bus.d2), 32'(m_d[2]));
        chk("cyc_d3", 32'(bus.d3), 32'(m_d[3]));
        chk("cyc_frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        chk("cyc_seg_err", 32'(bus.seg_err), 32'(m_err));
        chk("cyc_stale", 32'(bus.stale), 32'(m_to == TMO));
      end
    join_none

    repeat (3) @(negedge clk);
    chk_digits("reset", 4'hF, 4'hF, 4'hF, 4'hF);
    chk("reset_fv", 32'(bus.frame_valid), 0);
    chk("reset_err", 32'(bus.seg_err), 0);
    chk("reset_stale", 32'(bus.stale), 0);
    rst_n = 1'b1;
    idle(5);

    // 1: three rotations of 1,2,3,4
    f0 = fv_cnt;
    repeat (3) rotate(pat[1], pat[2], pat[3], pat[4]);
    idle(5);
    chk("t1_pulses", 32'(fv_cnt - f0), 3);
    chk_digits("t1", 4'h1, 4'h2, 4'h3, 4'h4);
    chk("t1_err", 32'(bus.seg_err), 0);

    // 2: segment glitching faster than the stability window
    f0 = fv_cnt;
    for (int i = 0; i < 40; i++) drive(AN_D2, (i % 2 == 0) ? pat[5] : pat[6], 5);
    idle(5);
    chk("t2_pulses", 32'(fv_cnt - f0), 0);
    chk_digits("t2", 4'h1, 4'h2, 4'h3, 4'h4);

    // 3: the 'A' pattern on d1
    f0 = fv_cnt;
    rotate(pat[1], pat[2], 7'b0001000, pat[4]);
    idle(5);
    chk("t3_pulses", 32'(fv_cnt - f0), 1);
`ifdef SEVEN_SEG_HEX_EN
    chk("t3_d1", 32'(bus.d1), 32'hA);
    chk("t3_err", 32'(bus.seg_err), 0);
`else
    chk("t3_d1", 32'(bus.d1), 32'hF);
    chk("t3_err", 32'(bus.seg_err), 1);
`endif

    // 4: blanks, then a two-low anode word that must be ignored
    f0 = fv_cnt;
    rotate(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    idle(5);
    chk("t4_pulses", 32'(fv_cnt - f0), 1);
    chk_digits("t4", 4'hF, 4'hF, 4'hF, 4'hF);
    chk("t4_err", 32'(bus.seg_err), 0);
    f0 = fv_cnt;
    drive(4'b1100, pat[5], 40);
    idle(5);
    chk("t4_drop_pulses", 32'(fv_cnt - f0), 0);
    chk_digits("t4_drop", 4'hF, 4'hF, 4'hF, 4'hF);

    // 5: timeout with a partial frame pending, then resume
    rotate(pat[9], pat[8], pat[7], pat[6]);
    scan(3, pat[2]);
    scan(2, pat[3]);
    idle(TMO + 50);
    chk("t5_stale", 32'(bus.stale), 1);
    chk_digits("t5_hold", 4'h9, 4'h8, 4'h7, 4'h6);
    f0 = fv_cnt;
    scan(1, pat[5]);
    chk("t5_stale_clear", 32'(bus.stale), 0);
    scan(0, pat[6]);
    chk("t5_partial_pulses", 32'(fv_cnt - f0), 0);
    scan(3, pat[1]);
    scan(2, pat[2]);
    chk("t5_pulses", 32'(fv_cnt - f0), 1);
    chk_digits("t5", 4'h1, 4'h2, 4'h5, 4'h6);

    // 6: reset in the middle of a frame
    scan(3, pat[7]);
    scan(2, pat[8]);
    drive(AN_D1, pat[9], 10);
    #2 rst_n = 1'b0;
    #1;
    chk_digits("t6_rst", 4'hF, 4'hF, 4'hF, 4'hF);
    chk("t6_rst_fv", 32'(bus.frame_valid), 0);
    chk("t6_rst_err", 32'(bus.seg_err), 0);
    chk("t6_rst_stale", 32'(bus.stale), 0);
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    f0 = fv_cnt;
    scan(1, pat[9]);
    scan(0, pat[0]);
    scan(3, pat[7]);
    chk("t6_partial_pulses", 32'(fv_cnt - f0), 0);
    scan(2, pat[8]);
    idle(5);
    chk("t6_pulses", 32'(fv_cnt - f0), 1);
    chk_digits("t6", 4'h7, 4'h8, 4'h9, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
